// File: rtl/lanectrl_delay_seq.sv
// Multi-lane delay-line sequencer: wraps each load/move command in a clock-pause window,
// pulses LOAD/MOVE toward the addressed lane and tracks a saturating tap per lane.
module lanectrl_delay_seq #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int MAX_TAP   = 255,
    parameter int INIT_TAP  = 1,
    parameter int PAUSE_CYC = 2,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       FAB_CLK,
    input  logic                       RESET_N,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [LANE_W-1:0]          CMD_LANE,
    input  logic                       CMD_OP,
    input  logic                       CMD_DIR,
    input  logic [TAP_W-1:0]           CMD_STEPS,
    output logic [NUM_LANES-1:0]       DELAY_LINE_SEL,
    output logic                       DELAY_LINE_LOAD,
    output logic                       DELAY_LINE_MOVE,
    output logic                       DELAY_LINE_DIRECTION,
    output logic                       HS_IO_CLK_PAUSE,
    output logic [NUM_LANES*TAP_W-1:0] TAP_VAL,
    output logic [NUM_LANES-1:0]       OUT_OF_RANGE,
    output logic                       DONE
);

    localparam int CNT_W = $clog2(PAUSE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYC - 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_LOAD, S_MOVE, S_GAP, S_TAIL, S_DONE
    } state_e;

    state_e                            state_q, state_d;
    logic [LANE_W-1:0]                 lane_q, lane_d;
    logic                              op_q, op_d;
    logic                              dir_q, dir_d;
    logic [TAP_W-1:0]                  rem_q, rem_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_LANES-1:0][TAP_W-1:0]   tap_q, tap_d;
    logic [NUM_LANES-1:0]              oor_q, oor_d;

    logic [TAP_W-1:0] cur_tap;
    logic             at_limit;
    logic             lane_ok;
    logic             active;

    // Zero-extend before comparing so a power-of-two lane count does not give a constant compare.
    assign lane_ok = 32'(CMD_LANE) < 32'(NUM_LANES);

    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        op_d     = op_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        tap_d    = tap_q;
        oor_d    = oor_q;
        cur_tap  = '0;
        DELAY_LINE_MOVE = 1'b0;

        for (int k = 0; k < NUM_LANES; k++) begin
            if (LANE_W'(k) == lane_q) cur_tap = tap_q[k];
        end
        // Saturation is judged on the current tap, before any step is applied.
        at_limit = dir_q ? (cur_tap == TAP_MAX) : (cur_tap == '0);

        unique case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    lane_d  = CMD_LANE;
                    op_d    = CMD_OP;
                    dir_d   = CMD_DIR;
                    rem_d   = CMD_STEPS;
                    cnt_d   = CNT_LAST;
                    state_d = lane_ok ? S_LEAD : S_DONE;
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_LAST;
                    if (!op_q)              state_d = S_LOAD;
                    else if (rem_q == '0)   state_d = S_TAIL;
                    else                    state_d = S_MOVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOAD: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (LANE_W'(k) == lane_q) begin
                        tap_d[k] = TAP_INIT;
                        oor_d[k] = 1'b0;
                    end
                end
                state_d = S_TAIL;
            end
            S_MOVE: begin
                if (at_limit) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (LANE_W'(k) == lane_q) oor_d[k] = 1'b1;
                    end
                    state_d = S_TAIL;
                end else begin
                    DELAY_LINE_MOVE = 1'b1;
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (LANE_W'(k) == lane_q)
                            tap_d[k] = dir_q ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
                    end
                    rem_d   = rem_q - TAP_W'(1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = (rem_q != '0) ? S_MOVE : S_TAIL;
            end
            S_TAIL: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            op_q    <= 1'b0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            // NOTE: the tap array is reset deliberately; it mirrors lanes that share this reset.
            tap_q   <= {NUM_LANES{TAP_INIT}};
            oor_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            oor_q   <= oor_d;
        end
    end

    assign active = (state_q == S_LEAD) || (state_q == S_LOAD) || (state_q == S_MOVE) ||
                    (state_q == S_GAP)  || (state_q == S_TAIL);

    always_comb begin
        DELAY_LINE_SEL = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (active && (LANE_W'(k) == lane_q)) DELAY_LINE_SEL[k] = 1'b1;
        end
    end

    assign CMD_READY            = (state_q == S_IDLE) && RESET_N;
    assign HS_IO_CLK_PAUSE      = active;
    assign DELAY_LINE_LOAD      = (state_q == S_LOAD);
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DONE                 = (state_q == S_DONE);
    assign TAP_VAL              = tap_q;
    assign OUT_OF_RANGE         = oor_q;

endmodule
